// File: rtl/butterfly_mac_accum.sv
// Radix-2 FFT butterfly accumulate-and-combine stage: accumulates B*W partial products,
// forms A+BW / A-BW with scale, round and saturate, and stages real/imag pairs to a valid/ready output.
module butterfly_mac_accum #(
    parameter int DW    = 16,
    parameter int ACC_W = DW + 2,
    parameter int SCALE = 1,
    parameter int SAT   = 1
) (
    input  logic          clk_MAC,
    input  logic          rst,
    input  logic          clr,
    input  logic          flag_clr,
    input  logic          prod_vld,
    input  logic          prod_sub,
    input  logic [DW-1:0] in_prod,
    input  logic [DW-1:0] in_A_R,
    input  logic [DW-1:0] in_A_I,
    input  logic          Ld_R,
    input  logic          Ld_I,
    output logic          ld_rdy,
    input  logic          out_rdy,
    output logic          out_vld,
    output logic [DW-1:0] OUT1_R,
    output logic [DW-1:0] OUT1_I,
    output logic [DW-1:0] OUT2_R,
    output logic [DW-1:0] OUT2_I,
    output logic          ovf,
    output logic          err
);
    // state  | meaning
    // EMPTY  | no part staged
    // HAVE_R | real pair staged, waiting for imag
    // HAVE_I | imag pair staged, waiting for real
    // BOTH   | full pair staged, output register busy
    typedef enum logic [1:0] {EMPTY, HAVE_R, HAVE_I, BOTH} state_t;

    // One guard bit over a+p plus one for the rounding add, so neither can wrap.
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] HALF = SW'((2 ** SCALE) / 2);
    localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    state_t state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [DW-1:0] stg_1r, stg_2r, stg_1i, stg_2i;
    logic [DW-1:0] nxt_1r, nxt_2r, nxt_1i, nxt_2i;
    logic [DW-1:0] a_sel;
    logic signed [SW-1:0] a_x, p_x, s1, s2;
    logic [DW:0] q1, q2;
    logic signed [ACC_W-1:0] prod_x;
    logic ld_r_ok, ld_i_ok, complete, xfer, err_set, ovf_set;

    function automatic logic [DW:0] scale_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = (s + HALF) >>> SCALE;
        if (r > MAXV)
            return {1'b1, (SAT != 0) ? MAXV[DW-1:0] : r[DW-1:0]};
        else if (r < MINV)
            return {1'b1, (SAT != 0) ? MINV[DW-1:0] : r[DW-1:0]};
        else
            return {1'b0, r[DW-1:0]};
    endfunction

    assign ld_rdy = (state != BOTH);
    assign prod_x = {{(ACC_W-DW){in_prod[DW-1]}}, in_prod};

    always_comb begin
        a_sel = Ld_R ? in_A_R : in_A_I;
        a_x   = {{(SW-DW){a_sel[DW-1]}}, a_sel};
        p_x   = {{(SW-ACC_W){acc[ACC_W-1]}}, acc};
        s1    = a_x + p_x;
        s2    = a_x - p_x;
        q1    = scale_sat(s1);
        q2    = scale_sat(s2);
    end

    always_comb begin
        ld_r_ok   = Ld_R && (state == EMPTY || state == HAVE_I);
        ld_i_ok   = Ld_I && !Ld_R && (state == EMPTY || state == HAVE_R);
        complete  = (state == BOTH) || (state == HAVE_R && ld_i_ok) || (state == HAVE_I && ld_r_ok);
        xfer      = complete && (!out_vld || out_rdy);
        err_set   = (Ld_R && Ld_I) || (Ld_R && !ld_r_ok) || (Ld_I && !Ld_R && !ld_i_ok);
        ovf_set   = (ld_r_ok || ld_i_ok) && (q1[DW] || q2[DW]);
        nxt_1r    = ld_r_ok ? q1[DW-1:0] : stg_1r;
        nxt_2r    = ld_r_ok ? q2[DW-1:0] : stg_2r;
        nxt_1i    = ld_i_ok ? q1[DW-1:0] : stg_1i;
        nxt_2i    = ld_i_ok ? q2[DW-1:0] : stg_2i;
        state_nxt = state;
        if (xfer)
            state_nxt = EMPTY;
        else if (complete)
            state_nxt = BOTH;
        else if (ld_r_ok)
            state_nxt = HAVE_R;
        else if (ld_i_ok)
            state_nxt = HAVE_I;
    end

    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            stg_1r  <= '0;
            stg_2r  <= '0;
            stg_1i  <= '0;
            stg_2i  <= '0;
            OUT1_R  <= '0;
            OUT2_R  <= '0;
            OUT1_I  <= '0;
            OUT2_I  <= '0;
            out_vld <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            // Any load, taken or rejected, pre-empts clr and the product this cycle.
            if (ld_r_ok || ld_i_ok)
                acc <= '0;
            else if (Ld_R || Ld_I)
                acc <= acc;
            else if (clr)
                acc <= '0;
            else if (prod_vld)
                acc <= prod_sub ? acc - prod_x : acc + prod_x;
            stg_1r <= nxt_1r;
            stg_2r <= nxt_2r;
            stg_1i <= nxt_1i;
            stg_2i <= nxt_2i;
            if (xfer) begin
                OUT1_R  <= nxt_1r;
                OUT2_R  <= nxt_2r;
                OUT1_I  <= nxt_1i;
                OUT2_I  <= nxt_2i;
                out_vld <= 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
            ovf <= (ovf && !flag_clr) || ovf_set;
            err <= (err && !flag_clr) || err_set;
        end
    end
endmodule
